pong_match_sequencer: RTL
=========================

# pong_match_sequencer

Match-level controller for the Pong game datapath. Sequences the collision/physics controller through attract, new-game, serve, play, point-pause, user pause and game-over phases by driving its frame-rate enable (`game_en`), round reset (`rst_n`) and score-clear (`gmv`) inputs. It also exposes phase, countdown and winner information to the video overlay. Sits between the video timing generator (frame tick), the debounced user buttons and the collision controller.

## Interface
Parameters:
- `SERVE_FRAMES`, 60: frames the ball is held at centre before play resumes; range 1..2^CNT_W-1.
- `POINT_FRAMES`, 30: frames of frozen play after a non-final point; range 1..2^CNT_W-1.
- `OVER_FRAMES`, 180: minimum frames in game-over before `start_btn` is honoured; range 1..2^CNT_W-1.
- `CNT_W`, 9: frame-counter width.

Ports:
- `clk`, in, 1: system clock; the only clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `frame_tick`, in, 1: one-cycle pulse per video frame.
- `start_btn`, in, 1: debounced level, synchronous to `clk`.
- `pause_btn`, in, 1: debounced level, synchronous to `clk`.
- `wall_col`, in, 1: point-scored flag from the collision controller (level, held several enables).
- `lossA`, in, 1: player A has reached 7 points against; valid in the cycle `wall_col` rises.
- `lossB`, in, 1: same, for player B.
- `game_en`, out, 1: one-cycle enable to the collision controller.
- `rst_n`, out, 1: active-low round reset to the collision controller.
- `gmv`, out, 1: score-clear qualifier, effective only while `rst_n`=0.
- `phase`, out, 3: current state encoding.
- `frame_cnt`, out, CNT_W: remaining frames of the current timed state; 0 otherwise.
- `winner`, out, 2: 01 means A won, 10 means B won, 00 means none.
- `paused`, out, 1: high in PAUSE.

## Operation
- States and encodings: IDLE=0, NEWGAME=1, SERVE=2, PLAY=3, POINT=4, PAUSE=5, OVER=6. Codes 7 and above recover to IDLE on the next clock.
- Edge detectors: registered copies of `start_btn`, `pause_btn` and `wall_col`, each reset to 0. An "edge" means the input is 1 now and the registered copy is 0.
- IDLE: start edge moves to NEWGAME.
- NEWGAME: on `frame_tick`, move to SERVE and load `frame_cnt`=SERVE_FRAMES.
- SERVE: on each `frame_tick`, decrement `frame_cnt`. A tick with `frame_cnt`=1 moves to PLAY with `frame_cnt`=0, so SERVE lasts exactly SERVE_FRAMES ticks.
- PLAY, `wall_col` edge:
  - If `lossA` is set, move to OVER with `winner`=10.
  - Else if `lossB` is set, move to OVER with `winner`=01.
  - Else move to POINT with `frame_cnt`=POINT_FRAMES.
  - OVER loads `frame_cnt`=OVER_FRAMES.
- PLAY, pause edge: move to PAUSE. A `wall_col` edge in the same cycle wins, and the pause edge is dropped.
- POINT: count down as in SERVE. The terminal tick moves to SERVE with `frame_cnt`=SERVE_FRAMES.
- PAUSE: pause edge moves back to PLAY. Start edges are ignored.
- OVER:
  - Count down to 0 on ticks, then hold at 0.
  - While `frame_cnt`≠0, start edges are ignored.
  - A start edge at `frame_cnt`=0 moves to NEWGAME and clears `winner`.
- Output decode, all registered, computed from the state before the transition:
  - IDLE, NEWGAME: `rst_n`=0, `gmv`=1.
  - SERVE: `rst_n`=0, `gmv`=0.
  - PLAY, POINT, PAUSE, OVER: `rst_n`=1, `gmv`=0.
- `game_en` is registered as `frame_tick` AND (state ∈ {NEWGAME, SERVE, PLAY}). Its effect per state:
  - NEWGAME: clears scores and positions.
  - SERVE: re-centres the ball and paddles every frame and keeps scores.
  - PLAY: advances physics.
  - POINT, PAUSE, OVER: no enable is issued; the datapath is frozen.
- `paused` = (state==PAUSE), registered.

## Timing
- Reset values: state IDLE, `game_en`=0, `rst_n`=0, `gmv`=0, `frame_cnt`=0, `winner`=00, `paused`=0, all edge registers 0. `gmv` becomes 1 on the first clock after reset deasserts.
- Latency:
  - `game_en` is high for exactly one cycle, the cycle after `frame_tick`.
  - `rst_n` and `gmv` in that cycle reflect the state at the tick.
  - `phase` updates one cycle after its trigger.
- Asserting `rst` in any state immediately forces the reset values. A frame tick or button edge coincident with `rst` deassertion is ignored.
- A `wall_col` level that carries over from POINT/SERVE into PLAY produces no edge and no new point.
- Counters never wrap: decrement happens only when `frame_cnt`>0.

## Test plan
- Reset, then start edge, then 2 ticks: NEWGAME tick gives `game_en`=1, `rst_n`=0, `gmv`=1. The next tick gives `game_en`=1, `rst_n`=0, `gmv`=0, and `phase`=2.
- With SERVE_FRAMES=3: exactly 3 SERVE ticks, then `phase`=3. The first PLAY tick gives `game_en`=1, `rst_n`=1.
- `wall_col` rises in PLAY with both loss flags 0: POINT with `frame_cnt`=POINT_FRAMES, no `game_en` for POINT_FRAMES ticks, then SERVE.
- `wall_col` rises with `lossA`=1 and a pause edge in the same cycle: `phase`=6, `winner`=10, `paused`=0. A start edge before OVER_FRAMES ticks is ignored; after them, it gives `phase`=1, `winner`=00.
- Pause edge in PLAY, then 5 ticks, then pause edge: `paused`=1, zero `game_en` pulses, return to `phase`=3.
- `rst` asserted mid-SERVE with `frame_cnt`=2: all outputs go to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/pong_match_sequencer.sv
// pong_match_sequencer
// Match-level controller for the Pong datapath. Steps the collision/physics
// controller through attract, new-game, serve, play, point-pause, user pause
// and game-over phases by driving its frame enable, round reset and
// score-clear inputs, and reports phase/countdown/winner to the overlay.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   frame_tick one-cycle pulse per video frame
//   start_btn  debounced start button level
//   pause_btn  debounced pause button level
//   wall_col   point-scored level from the collision controller
//   lossA/B    player A/B has reached the losing score (valid as wall_col rises)
//   game_en    one-cycle enable to the collision controller
//   rst_n      active-low round reset to the collision controller
//   gmv        score-clear qualifier, meaningful while rst_n = 0
//   phase      current state code
//   frame_cnt  remaining frames of a timed state, 0 otherwise
//   winner     01 = A won, 10 = B won, 00 = none
//   paused     high while in PAUSE
module pong_match_sequencer #(
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 30,
  parameter int unsigned OVER_FRAMES  = 180,
  parameter int unsigned CNT_W        = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             start_btn,
  input  logic             pause_btn,
  input  logic             wall_col,
  input  logic             lossA,
  input  logic             lossB,
  output logic             game_en,
  output logic             rst_n,
  output logic             gmv,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [1:0]       winner,
  output logic             paused
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    NEWGAME = 3'd1,
    SERVE   = 3'd2,
    PLAY    = 3'd3,
    POINT   = 3'd4,
    PAUSE   = 3'd5,
    OVER    = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] POINT_LOAD = CNT_W'(POINT_FRAMES);
  localparam logic [CNT_W-1:0] OVER_LOAD  = CNT_W'(OVER_FRAMES);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       winner_q;
  logic             start_q, pause_q, wall_q;
  logic             game_en_q, rst_n_q, gmv_q, paused_q;

  logic start_edge, pause_edge, wall_edge;
  logic cnt_last;

  assign start_edge = start_btn & ~start_q;
  assign pause_edge = pause_btn & ~pause_q;
  assign wall_edge  = wall_col  & ~wall_q;
  // Terminal tick of a countdown; a zero count is treated as already expired.
  assign cnt_last   = (cnt_q <= CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      winner_q  <= '0;
      start_q   <= 1'b0;
      pause_q   <= 1'b0;
      wall_q    <= 1'b0;
      game_en_q <= 1'b0;
      rst_n_q   <= 1'b0;
      gmv_q     <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      start_q <= start_btn;
      pause_q <= pause_btn;
      wall_q  <= wall_col;

      // Outputs decode the state present before this clock's transition.
      game_en_q <= frame_tick &
                   ((state_q == NEWGAME) || (state_q == SERVE) || (state_q == PLAY));
      rst_n_q   <= (state_q == PLAY) || (state_q == POINT) ||
                   (state_q == PAUSE) || (state_q == OVER);
      gmv_q     <= (state_q == IDLE) || (state_q == NEWGAME);
      paused_q  <= (state_q == PAUSE);

      case (state_q)
        IDLE: begin
          if (start_edge) state_q <= NEWGAME;
        end
        NEWGAME: begin
          if (frame_tick) begin
            state_q <= SERVE;
            cnt_q   <= SERVE_LOAD;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            if (cnt_last) begin
              state_q <= PLAY;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end
        PLAY: begin
          // A point takes priority over a simultaneous pause request.
          if (wall_edge) begin
            if (lossA) begin
              state_q  <= OVER;
              winner_q <= 2'b10;
              cnt_q    <= OVER_LOAD;
            end else if (lossB) begin
              state_q  <= OVER;
              winner_q <= 2'b01;
              cnt_q    <= OVER_LOAD;
            end else begin
              state_q <= POINT;
              cnt_q   <= POINT_LOAD;
            end
          end else if (pause_edge) begin
            state_q <= PAUSE;
          end
        end
        POINT: begin
          if (frame_tick) begin
            if (cnt_last) begin
              state_q <= SERVE;
              cnt_q   <= SERVE_LOAD;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end
        PAUSE: begin
          if (pause_edge) state_q <= PLAY;
        end
        OVER: begin
          if (cnt_q != '0) begin
            if (frame_tick) cnt_q <= cnt_q - CNT_W'(1);
          end else if (start_edge) begin
            state_q  <= NEWGAME;
            winner_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign game_en   = game_en_q;
  assign rst_n     = rst_n_q;
  assign gmv       = gmv_q;
  assign phase     = state_q;
  assign frame_cnt = cnt_q;
  assign winner    = winner_q;
  assign paused    = paused_q;

endmodule
